// File: rtl/ws2812_pkg.sv
// Shared WS2812 definitions: GRB pixel layout, line timing in 50 MHz cycles and receiver states.
package ws2812_pkg;

  localparam int T0H_CYC          = 20;
  localparam int T1H_CYC          = 40;
  localparam int TBIT_CYC         = 62;
  localparam int TRESET_CYC       = 2500;
  localparam int T_BIT_THRESH_DEF = 30;
  localparam int T_MIN_HIGH_DEF   = 5;
  localparam int T_MAX_HIGH_DEF   = 60;
  localparam int MAX_PIXELS_DEF   = 256;

  typedef struct packed {
    logic [7:0] g;
    logic [7:0] r;
    logic [7:0] b;
  } rgb_t;

  typedef enum logic [1:0] {SYNC_WAIT, LOW, HIGH} rx_state_t;

endpackage

// File: rtl/ws2812_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line plus rise/fall detection on the synchronized level.
module ws2812_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic din_s,
  output logic rise,
  output logic fall
);

  logic sync_p0;
  logic din_s_p1;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0  <= 1'b0;
      din_s    <= 1'b0;
      din_s_p1 <= 1'b0;
    end else begin
      sync_p0  <= din;
      din_s    <= sync_p0;
      din_s_p1 <= din_s;
    end
  end

  assign rise = din_s & ~din_s_p1;
  assign fall = ~din_s & din_s_p1;

endmodule

// File: rtl/ws2812_rx.sv
// WS2812 NRZ receiver: classifies high-pulse widths into bits, assembles GRB pixels,
// keeps pixel 0 of each frame and forwards the rest of the stream on dout.
module ws2812_rx
  import ws2812_pkg::*;
#(
  parameter int T_BIT_THRESH_CYC = T_BIT_THRESH_DEF,
  parameter int T_MIN_HIGH_CYC   = T_MIN_HIGH_DEF,
  parameter int T_MAX_HIGH_CYC   = T_MAX_HIGH_DEF,
  parameter int T_RESET_CYC      = TRESET_CYC,
  parameter int MAX_PIXELS       = MAX_PIXELS_DEF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          din,
  output logic                          dout,
  output logic [23:0]                   pixel_data,
  output logic                          pixel_valid,
  output logic [$clog2(MAX_PIXELS)-1:0] pixel_index,
  output logic [23:0]                   own_color,
  output logic                          frame_done,
  output logic                          bit_error
);

  localparam int CNT_W = $clog2(T_RESET_CYC + 1);
  localparam int IDX_W = $clog2(MAX_PIXELS);
  localparam logic [CNT_W-1:0] CNT_RESET  = CNT_W'(T_RESET_CYC);
  localparam logic [CNT_W-1:0] CNT_THRESH = CNT_W'(T_BIT_THRESH_CYC);
  localparam logic [CNT_W-1:0] CNT_MIN    = CNT_W'(T_MIN_HIGH_CYC);
  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(T_MAX_HIGH_CYC);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(MAX_PIXELS - 1);

  logic din_s, rise, fall;

  ws2812_rx_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .din   (din),
    .din_s (din_s),
    .rise  (rise),
    .fall  (fall)
  );

  rx_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [4:0]       bit_cnt;
  logic [IDX_W-1:0] pix_cnt;
  logic [23:0]      shift_p0;
  logic             fwd_arm, fwd_en, any_bit;
  logic             shift_en, bit_val;

  always_comb begin
    shift_en = (state == HIGH) && fall && (cnt >= CNT_MIN);
    bit_val  = (cnt > CNT_THRESH);
  end

  // Bit stage: MSB-first shift, no reset needed since bit_cnt gates its use
  always_ff @(posedge clk) begin
    if (shift_en) shift_p0 <= {shift_p0[22:0], bit_val};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= SYNC_WAIT;
      cnt         <= '0;
      bit_cnt     <= '0;
      pix_cnt     <= '0;
      fwd_arm     <= 1'b0;
      fwd_en      <= 1'b0;
      any_bit     <= 1'b0;
      dout        <= 1'b0;
      pixel_data  <= '0;
      pixel_valid <= 1'b0;
      pixel_index <= '0;
      own_color   <= '0;
      frame_done  <= 1'b0;
      bit_error   <= 1'b0;
    end else begin
      pixel_valid <= 1'b0;
      frame_done  <= 1'b0;
      bit_error   <= 1'b0;
      dout        <= din_s & fwd_en;

      // Only open the forward path while the line is low so the first pulse passes whole
      if (fwd_arm && !din_s) begin
        fwd_en  <= 1'b1;
        fwd_arm <= 1'b0;
      end

      // Pixel stage: runs the cycle after the 24th shift
      if (bit_cnt == 5'd24) begin
        pixel_data  <= shift_p0;
        pixel_valid <= 1'b1;
        pixel_index <= pix_cnt;
        bit_cnt     <= '0;
        if (pix_cnt != IDX_LAST) pix_cnt <= pix_cnt + 1'b1;
        if (pix_cnt == '0) begin
          own_color <= shift_p0;
          fwd_arm   <= 1'b1;
        end
      end

      unique case (state)
        SYNC_WAIT: begin
          if (din_s) begin
            cnt <= '0;
          end else if (cnt == CNT_RESET - 1'b1) begin
            cnt     <= CNT_RESET;
            state   <= LOW;
            pix_cnt <= '0;
            any_bit <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        LOW: begin
          if (rise) begin
            cnt   <= '0;
            state <= HIGH;
          end else if (cnt == CNT_RESET - 1'b1) begin
            cnt        <= CNT_RESET;
            bit_error  <= (bit_cnt != '0);
            frame_done <= any_bit;
            any_bit    <= 1'b0;
            pix_cnt    <= '0;
            bit_cnt    <= '0;
            fwd_en     <= 1'b0;
            fwd_arm    <= 1'b0;
          end else if (cnt != CNT_RESET) begin
            cnt <= cnt + 1'b1;
          end
        end
        HIGH: begin
          if (fall) begin
            cnt   <= '0;
            state <= LOW;
            if (cnt < CNT_MIN) begin
              bit_error <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              any_bit <= 1'b1;
            end
          end else if (cnt == CNT_MAX - 1'b1) begin
            bit_error <= 1'b1;
            bit_cnt   <= '0;
            fwd_en    <= 1'b0;
            fwd_arm   <= 1'b0;
            cnt       <= '0;
            state     <= SYNC_WAIT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= SYNC_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_ws2812_rx.sv
// Directed bench for ws2812_rx: drives WS2812 waveforms and checks decoded pixels, strobes and forwarding.
module tb_ws2812_rx;
  import ws2812_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        din = 1'b0;
  logic        dout;
  logic [23:0] pixel_data;
  logic        pixel_valid;
  logic [7:0]  pixel_index;
  logic [23:0] own_color;
  logic        frame_done;
  logic        bit_error;

  ws2812_rx dut (
    .clk         (clk),
    .reset       (reset),
    .din         (din),
    .dout        (dout),
    .pixel_data  (pixel_data),
    .pixel_valid (pixel_valid),
    .pixel_index (pixel_index),
    .own_color   (own_color),
    .frame_done  (frame_done),
    .bit_error   (bit_error)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          pv_n    = 0;
  int          fd_n    = 0;
  int          be_n    = 0;
  int          dhi_n   = 0;
  int          dn      = 0;
  int          run     = 0;
  logic        dprev   = 1'b0;
  logic [23:0] pv_data [64];
  logic [7:0]  pv_idx  [64];
  int          dw      [128];
  int          drise   [128];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (pixel_valid) begin
      if (pv_n < 64) begin
        pv_data[pv_n] <= pixel_data;
        pv_idx[pv_n]  <= pixel_index;
      end
      pv_n <= pv_n + 1;
    end
    if (frame_done) fd_n <= fd_n + 1;
    if (bit_error)  be_n <= be_n + 1;
    if (dout) dhi_n <= dhi_n + 1;
    dprev <= dout;
    if (dout && !dprev && dn < 128) drise[dn] <= cyc;
    if (dout) begin
      run <= run + 1;
    end else if (run != 0) begin
      if (dn < 128) dw[dn] <= run;
      dn  <= dn + 1;
      run <= 0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input int n);
    din = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b);
    drive(1'b1, b ? T1H_CYC : T0H_CYC);
    drive(1'b0, b ? (TBIT_CYC - T1H_CYC) : (TBIT_CYC - T0H_CYC));
  endtask

  task automatic send_bits(input logic [23:0] w, input int n);
    for (int i = 0; i < n; i++) send_bit(w[23-i]);
  endtask

  task automatic send_pixel_g(input logic [23:0] w, input int glitch_after);
    for (int i = 0; i < 24; i++) begin
      send_bit(w[23-i]);
      if (i == glitch_after) begin
        drive(1'b0, 10);
        drive(1'b1, 3);
        drive(1'b0, 10);
      end
    end
  endtask

  task automatic gap();
    drive(1'b0, 2600);
  endtask

  initial begin
    int pv0, fd0, be0, dn0, dh0, t0;
    logic [23:0] p1, p2;
    @(posedge clk);
    #1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("rst_pixel_data", 32'(pixel_data), 32'h0);
    check("rst_pixel_valid", 32'(pixel_valid), 32'h0);
    check("rst_pixel_index", 32'(pixel_index), 32'h0);
    check("rst_own_color", 32'(own_color), 32'h0);
    check("rst_frame_done", 32'(frame_done), 32'h0);
    check("rst_bit_error", 32'(bit_error), 32'h0);
    check("rst_dout", 32'(dout), 32'h0);
    check("rst_state", 32'(dut.state), 32'(SYNC_WAIT));
    reset = 1'b0;

    // single pixel frame
    pv0 = pv_n; fd0 = fd_n; be0 = be_n; dh0 = dhi_n;
    gap();
    send_pixel_g(24'hFF0000, -1);
    gap();
    check("t1_pv_count", 32'(pv_n - pv0), 32'd1);
    check("t1_data", 32'(pv_data[pv0]), 32'hFF0000);
    check("t1_index", 32'(pv_idx[pv0]), 32'd0);
    check("t1_own", 32'(own_color), 32'hFF0000);
    check("t1_fd_count", 32'(fd_n - fd0), 32'd1);
    check("t1_be_count", 32'(be_n - be0), 32'd0);
    check("t1_dout_quiet", 32'(dhi_n - dh0), 32'd0);

    // three pixels with forwarding
    pv0 = pv_n; fd0 = fd_n; dn0 = dn;
    p1 = 24'h0000FF;
    p2 = 24'hFFFF00;
    send_pixel_g(24'hFFFFFF, -1);
    t0 = cyc;
    send_pixel_g(p1, -1);
    send_pixel_g(p2, -1);
    gap();
    check("t2_pv_count", 32'(pv_n - pv0), 32'd3);
    check("t2_data0", 32'(pv_data[pv0]), 32'hFFFFFF);
    check("t2_data1", 32'(pv_data[pv0+1]), 32'h0000FF);
    check("t2_data2", 32'(pv_data[pv0+2]), 32'hFFFF00);
    check("t2_idx0", 32'(pv_idx[pv0]), 32'd0);
    check("t2_idx1", 32'(pv_idx[pv0+1]), 32'd1);
    check("t2_idx2", 32'(pv_idx[pv0+2]), 32'd2);
    check("t2_own", 32'(own_color), 32'hFFFFFF);
    check("t2_fd_count", 32'(fd_n - fd0), 32'd1);
    check("t2_dout_pulses", 32'(dn - dn0), 32'd48);
    check("t2_dout_delay", 32'(drise[dn0]), 32'(t0 + 3));
    for (int k = 0; k < 48; k++) begin
      logic b;
      b = (k < 24) ? p1[23-k] : p2[47-k];
      check($sformatf("t2_dout_w%0d", k), 32'(dw[dn0+k]), b ? 32'd40 : 32'd20);
    end

    // start mid-stream with no leading gap
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    pv0 = pv_n; be0 = be_n;
    drive(1'b1, 15);
    drive(1'b0, 22);
    send_pixel_g(24'h123456, -1);
    check("t3_no_lock", 32'(pv_n - pv0), 32'd0);
    gap();
    fd0 = fd_n;
    send_pixel_g(24'h5A3C96, -1);
    gap();
    check("t3_pv_count", 32'(pv_n - pv0), 32'd1);
    check("t3_data", 32'(pv_data[pv0]), 32'h5A3C96);
    check("t3_index", 32'(pv_idx[pv0]), 32'd0);
    check("t3_fd_count", 32'(fd_n - fd0), 32'd1);
    check("t3_be_count", 32'(be_n - be0), 32'd0);

    // glitch between bits
    pv0 = pv_n; be0 = be_n;
    send_pixel_g(24'hA5C3E1, 7);
    gap();
    check("t4_glitch_be", 32'(be_n - be0), 32'd1);
    check("t4_glitch_pv", 32'(pv_n - pv0), 32'd1);
    check("t4_glitch_data", 32'(pv_data[pv0]), 32'hA5C3E1);

    // overlong high
    be0 = be_n; fd0 = fd_n; pv0 = pv_n;
    drive(1'b1, 70);
    check("t4_ovl_be", 32'(be_n - be0), 32'd1);
    check("t4_ovl_state", 32'(dut.state), 32'(SYNC_WAIT));
    gap();
    check("t4_ovl_no_fd", 32'(fd_n - fd0), 32'd0);
    send_pixel_g(24'h0F0F0F, -1);
    gap();
    check("t4_rec_data", 32'(pv_data[pv0]), 32'h0F0F0F);
    check("t4_rec_index", 32'(pv_idx[pv0]), 32'd0);

    // partial pixel at latch
    pv0 = pv_n; be0 = be_n; fd0 = fd_n;
    send_bits(24'hAC8000, 10);
    gap();
    check("t5_pv_none", 32'(pv_n - pv0), 32'd0);
    check("t5_be", 32'(be_n - be0), 32'd1);
    check("t5_fd", 32'(fd_n - fd0), 32'd1);
    send_pixel_g(24'h112233, -1);
    gap();
    check("t5_next_data", 32'(pv_data[pv0]), 32'h112233);
    check("t5_next_index", 32'(pv_idx[pv0]), 32'd0);

    // reset mid-pixel
    send_bits(24'hCAFE00, 12);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("t6_rst_pixel_data", 32'(pixel_data), 32'h0);
    check("t6_rst_own", 32'(own_color), 32'h0);
    check("t6_rst_index", 32'(pixel_index), 32'h0);
    check("t6_rst_strobes", 32'({pixel_valid, frame_done, bit_error, dout}), 32'h0);
    pv0 = pv_n;
    send_bits(24'hCAFE00 << 12, 12);
    send_pixel_g(24'h445566, -1);
    check("t6_ignored", 32'(pv_n - pv0), 32'd0);
    gap();
    send_pixel_g(24'h778899, -1);
    gap();
    check("t6_pv_count", 32'(pv_n - pv0), 32'd1);
    check("t6_data", 32'(pv_data[pv0]), 32'h778899);
    check("t6_index", 32'(pv_idx[pv0]), 32'd0);
    check("t6_own", 32'(own_color), 32'h778899);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ws2812_rx.md
Name: ws2812_rx

Overview:
- Single-wire WS2812 NRZ receiver/decoder. It is the counterpart of the fade system's ws2812 driver.
- It samples the serial line, classifies each bit by its high-pulse width, and assembles 24-bit GRB pixels. It detects the reset/latch gap.
- Like a physical WS2812, it keeps the first pixel of each frame and forwards the remaining bits on a daisy-chain output.
- It serves as the on-chip loopback checker for the LED pipeline and as an input for chained boards.

Parameters:
- T_BIT_THRESH_CYC, 30: high-pulse cycles; a width above this decodes as 1, at or below as 0 (T0H = 20, T1H = 40 at 50 MHz).
- T_MIN_HIGH_CYC, 5: high pulses shorter than this are glitches.
- T_MAX_HIGH_CYC, 60: a high pulse reaching this width is a protocol error.
- T_RESET_CYC, 2500: low cycles (50 us) that constitute a latch/reset gap.
- MAX_PIXELS, 256: pixel_index range; the index saturates at MAX_PIXELS-1.

Ports:
- clk, in, 1: system clock, 50 MHz.
- reset, in, 1: synchronous, active-high reset.
- din, in, 1: asynchronous WS2812 serial input.
- dout, out, 1: daisy-chain output; forwarded din after this device's pixel.
- pixel_data, out, 24: last decoded pixel, {G[23:16], R[15:8], B[7:0]}.
- pixel_valid, out, 1: one-cycle strobe when pixel_data updates.
- pixel_index, out, $clog2(MAX_PIXELS): index of the pixel_data pixel within the frame.
- own_color, out, 24: pixel 0 of the most recent frame; holds until the next pixel 0 completes.
- frame_done, out, 1: one-cycle strobe on a latch gap when at least 1 bit was received.
- bit_error, out, 1: one-cycle strobe on a glitch, an overlong high, or a partial pixel at latch.

Behaviour:
Reset values:
- All outputs are 0 and all counters are 0.
- State is SYNC_WAIT.
- The synchronizer flops are 0.

Input path:
- din passes through a 2-flop synchronizer (din_s).
- Edges are detected against the registered din_s.
- Decode latency from a line edge to an internal event is 3 clk.

State machine:
- SYNC_WAIT:
  - Count consecutive low cycles; any high clears the count.
  - When the count reaches T_RESET_CYC, go to LOW. This prevents locking on mid-stream.
  - frame_done is not issued from this state.
- LOW:
  - Count low cycles.
  - On a rising edge, clear the high counter and go to HIGH.
  - When the low count reaches T_RESET_CYC, perform the latch and stay in LOW with the counter held.
- HIGH:
  - Count high cycles.
  - When the high count reaches T_MAX_HIGH_CYC: pulse bit_error, discard the partial pixel, clear bit_cnt and fwd_en, and go to SYNC_WAIT.
  - On a falling edge with count < T_MIN_HIGH_CYC: pulse bit_error, leave the shift register unchanged, and go to LOW.
  - On any other falling edge: shift bit = (count > T_BIT_THRESH_CYC) into the LSB of the 24-bit shift register (MSB first on the wire), increment bit_cnt, and go to LOW with the low counter cleared.

Pixel completion (bit_cnt reaches 24):
- On the cycle after the 24th shift, pixel_data is loaded with the shift register, pixel_valid pulses, and bit_cnt returns to 0.
- pixel_index takes the frame pixel counter value; the counter then increments and saturates at MAX_PIXELS-1.
- If pixel_index = 0: own_color is loaded and fwd_en is set.

Latch:
- If bit_cnt != 0, pulse bit_error and discard the partial bits.
- If any bit was received since the last latch, pulse frame_done.
- Clear the pixel counter, bit_cnt and fwd_en.
- pixel_valid and frame_done never pulse in the same cycle.

Forwarding:
- dout = din_s & fwd_en, registered.
- fwd_en is set while the line is low, so the first forwarded pulse is whole.
- dout is forced to 0 whenever fwd_en = 0.

Counters:
- Width is $clog2(T_RESET_CYC+1).
- Counters saturate and never wrap.

Reset mid-frame:
- All state and outputs return to reset values.
- The receiver must see a full low gap again before decoding.

Decomposition:
- Package ws2812_pkg:
  - the rgb_t packed struct {g, r, b}
  - the timing localparams (T0H/T1H/TRESET in cycles at 50 MHz)
  - the rx_state_t enum {SYNC_WAIT, LOW, HIGH}
- The driver shares the timing constants from the package.
- One sub-module, ws2812_rx_sync: 2-flop synchronizer plus rise/fall edge detect. Everything else lives in ws2812_rx.

Test Plan:
- Power-up, then 2600 low cycles, then one pixel 0xFF_00_00 (T1H = 40 / T0H = 20, period 62 cycles), then 2600 low cycles -> one pixel_valid with pixel_data = FF0000 and index 0; own_color = FF0000; one frame_done; dout stays 0.
- Three pixels FFFFFF, 0000FF, FFFF00, then a latch -> pixel_valid with indices 0, 1, 2 and matching data; own_color = FFFFFF; dout reproduces exactly the 48 bits of pixels 1 and 2, delayed 3 clk, with no truncated first pulse.
- Stream starting mid-bit with no preceding 2500-cycle low -> no pixel_valid until a gap is seen; the first decoded pixel after the gap is correct.
- 3-cycle glitch inserted between bits -> bit_error pulses once; the surrounding pixel still decodes correctly. A 70-cycle high -> bit_error pulses and the state goes to SYNC_WAIT.
- 10 bits followed by a latch -> bit_error and frame_done pulse once each; no pixel_valid; the next frame starts at index 0.
- reset asserted for 1 cycle after bit 12 of a pixel -> all outputs are 0 next cycle; remaining bits are ignored until a full gap, then normal decode resumes.
